// File: rtl/alu_exec_ctrl_if.sv
// Instruction and accumulator-output handshakes of the execute-stage controller.
// The slave side is the controller, the master side is the instruction source / result sink.
interface alu_exec_ctrl_if;
    logic       instr_valid;
    logic       instr_ready;
    logic [9:0] instr;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;

    modport master (
        output instr_valid, instr, out_ready,
        input  instr_ready, out_valid, out_data
    );

    modport slave (
        input  instr_valid, instr, out_ready,
        output instr_ready, out_valid, out_data
    );
endinterface

// File: rtl/alu_exec_ctrl.sv
// Execute-stage controller wrapped around a 4-bit ALU: loads A/B, holds the ALU
// inputs for a settle window, writes F back to the accumulator and offers it downstream.
module alu_exec_ctrl #(
    parameter int SETTLE_CYCLES = 1,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    alu_exec_ctrl_if.slave   bus,
    output logic [3:0]       alu_sel,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    output logic             alu_m,
    output logic             alu_cn,
    input  logic [3:0]       alu_f,
    input  logic             alu_abflag,
    output logic             ab_flag,
    output logic             zero_flag,
    output logic             busy,
    output logic [CNT_W-1:0] op_count
);
    localparam logic [1:0] C_LDA  = 2'b00;
    localparam logic [1:0] C_LDB  = 2'b01;
    localparam logic [1:0] C_EXEC = 2'b10;
    localparam logic [1:0] C_OUT  = 2'b11;
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_OUT  = 2'b10
    } state_t;

    state_t     state;
    logic [3:0] acc;
    logic [3:0] breg;
    logic [3:0] cnt;
    logic       unused_instr;

    // instr[7:6] carry no meaning for any class
    assign unused_instr    = ^bus.instr[7:6];

    assign bus.instr_ready = (state == S_IDLE);
    assign busy            = (state != S_IDLE);
    assign alu_a           = acc;
    assign alu_b           = breg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            acc           <= 4'd0;
            breg          <= 4'd0;
            cnt           <= 4'd0;
            alu_sel       <= 4'd0;
            alu_m         <= 1'b0;
            alu_cn        <= 1'b0;
            ab_flag       <= 1'b0;
            zero_flag     <= 1'b0;
            op_count      <= '0;
            bus.out_valid <= 1'b0;
            bus.out_data  <= 4'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.instr_valid) begin
                        case (bus.instr[9:8])
                            C_LDA: acc  <= bus.instr[3:0];
                            C_LDB: breg <= bus.instr[3:0];
                            C_EXEC: begin
                                alu_sel <= bus.instr[3:0];
                                alu_m   <= bus.instr[5];
                                alu_cn  <= bus.instr[4];
                                cnt     <= SETTLE_LOAD;
                                state   <= S_EXEC;
                            end
                            C_OUT: begin
                                bus.out_data  <= acc;
                                bus.out_valid <= 1'b1;
                                state         <= S_OUT;
                            end
                            default: state <= S_IDLE;
                        endcase
                    end
                end
                // ALU inputs are frozen here; F is sampled only once the window expires
                S_EXEC: begin
                    if (cnt == 4'd0) begin
                        acc       <= alu_f;
                        ab_flag   <= alu_abflag;
                        zero_flag <= (alu_f == 4'd0);
                        op_count  <= op_count + 1'b1;
                        state     <= S_IDLE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                S_OUT: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        state         <= S_IDLE;
                    end
                end
                default: begin
                    bus.out_valid <= 1'b0;
                    state         <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Bench for alu_exec_ctrl: two instances (settle 1 and 3) share stimulus via a select,
// each driven by a small stand-in ALU; writebacks and outputs are checked from a scoreboard.
module tb_alu_exec_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       dsel = 1'b0;
    logic       ivalid = 1'b0;
    logic [9:0] instr = '0;
    logic       oready = 1'b0;

    alu_exec_ctrl_if b1 ();
    alu_exec_ctrl_if b3 ();
    logic [3:0] sel1, a1, bb1, f1, sel3, a3, bb3, f3;
    logic       m1, cn1, m3, cn3, abf1, abf3, zf1, zf3, ab1, ab3, busy1, busy3;
    logic [7:0] cnt1, cnt3;

    function automatic logic [3:0] alu_fn(logic [3:0] s, logic [3:0] a, logic [3:0] b,
                                          logic m, logic cn);
        if (m) return (s == 4'd14) ? a + b : ~a;
        case (s)
            4'd1:    return a + b + {3'b000, ~cn};
            4'd3:    return cn ? 4'hF : 4'h0;
            default: return a ^ b;
        endcase
    endfunction

    function automatic logic abf_fn(logic [3:0] s, logic m, logic [3:0] f);
        return (f == 4'hF) || (s == 4'd3 && !m);
    endfunction

    assign f1   = alu_fn(sel1, a1, bb1, m1, cn1);
    assign abf1 = abf_fn(sel1, m1, f1);
    assign f3   = alu_fn(sel3, a3, bb3, m3, cn3);
    assign abf3 = abf_fn(sel3, m3, f3);

    assign b1.instr_valid = ivalid && !dsel;
    assign b3.instr_valid = ivalid && dsel;
    assign b1.instr       = instr;
    assign b3.instr       = instr;
    assign b1.out_ready   = oready && !dsel;
    assign b3.out_ready   = oready && dsel;

    alu_exec_ctrl #(.SETTLE_CYCLES(1), .CNT_W(8)) u1 (
        .clk(clk), .rst(rst), .bus(b1.slave),
        .alu_sel(sel1), .alu_a(a1), .alu_b(bb1), .alu_m(m1), .alu_cn(cn1),
        .alu_f(f1), .alu_abflag(abf1), .ab_flag(ab1), .zero_flag(zf1),
        .busy(busy1), .op_count(cnt1));

    alu_exec_ctrl #(.SETTLE_CYCLES(3), .CNT_W(8)) u3 (
        .clk(clk), .rst(rst), .bus(b3.slave),
        .alu_sel(sel3), .alu_a(a3), .alu_b(bb3), .alu_m(m3), .alu_cn(cn3),
        .alu_f(f3), .alu_abflag(abf3), .ab_flag(ab3), .zero_flag(zf3),
        .busy(busy3), .op_count(cnt3));

    // observed view of the selected instance
    wire       w_ready = dsel ? b3.instr_ready : b1.instr_ready;
    wire       w_ov    = dsel ? b3.out_valid   : b1.out_valid;
    wire [3:0] w_od    = dsel ? b3.out_data    : b1.out_data;
    wire [3:0] w_sel   = dsel ? sel3  : sel1;
    wire [3:0] w_a     = dsel ? a3    : a1;
    wire [3:0] w_b     = dsel ? bb3   : bb1;
    wire       w_m     = dsel ? m3    : m1;
    wire       w_cn    = dsel ? cn3   : cn1;
    wire       w_ab    = dsel ? ab3   : ab1;
    wire       w_zf    = dsel ? zf3   : zf1;
    wire       w_busy  = dsel ? busy3 : busy1;
    wire [7:0] w_cnt   = dsel ? cnt3  : cnt1;

    typedef struct packed {
        logic [3:0] acc;
        logic       abf;
        logic       zf;
        logic [7:0] cnt;
    } wb_t;

    wb_t        wb_q[$];
    logic [3:0] out_q[$];
    logic [3:0] m_acc, m_b;
    logic [7:0] m_cnt;
    int         settle;
    int         checks = 0;
    int         errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_acc = 0; m_b = 0; m_cnt = 0;
        wb_q.delete();
        out_q.delete();
    endtask

    // one-cycle instruction issue; controller must be idle
    task automatic issue(input logic [9:0] ins);
        wb_t        e;
        logic [3:0] f;
        ivalid = 1'b1;
        instr  = ins;
        @(posedge clk);
        #1;
        ivalid = 1'b0;
        case (ins[9:8])
            2'b00: m_acc = ins[3:0];
            2'b01: m_b   = ins[3:0];
            2'b10: begin
                f      = alu_fn(ins[3:0], m_acc, m_b, ins[5], ins[4]);
                m_cnt  = m_cnt + 8'd1;
                e.acc  = f;
                e.abf  = abf_fn(ins[3:0], ins[5], f);
                e.zf   = (f == 4'd0);
                e.cnt  = m_cnt;
                wb_q.push_back(e);
                m_acc  = f;
            end
            default: out_q.push_back(m_acc);
        endcase
    endtask

    // follow an EXEC to writeback, checking input stability and busy length
    task automatic wait_wb(input string tag);
        wb_t        e;
        int         n = 0;
        logic [3:0] s0, a0, b0;
        s0 = w_sel; a0 = w_a; b0 = w_b;
        forever begin
            @(negedge clk);
            if (!w_busy || n > 40) break;
            n++;
            if (w_sel !== s0 || w_a !== a0 || w_b !== b0)
                chk({tag, "_stable"}, {w_sel, w_a, w_b}, {s0, a0, b0});
        end
        chk({tag, "_busy_cycles"}, n, settle);
        if (wb_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 0, 1);
        end else begin
            e = wb_q.pop_front();
            chk({tag, "_acc"}, w_a, e.acc);
            chk({tag, "_abf"}, w_ab, e.abf);
            chk({tag, "_zf"}, w_zf, e.zf);
            chk({tag, "_cnt"}, w_cnt, e.cnt);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #7;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        settle = 1;
        #12;
        chk("rst_busy", {w_busy, w_ov, w_ab, w_zf}, 4'b0000);
        chk("rst_alu", {w_sel, w_a, w_b, w_m, w_cn}, 14'd0);
        chk("rst_cnt_od", {w_cnt, w_od}, 12'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_ready", w_ready, 1'b1);

        // LDA 5, LDB 3, EXEC add with Cn=1
        issue(10'b00_0000_0101);
        issue(10'b01_0000_0011);
        issue(10'b10_00_0_1_0001);
        chk("exec1_inputs", {w_a, w_b, w_sel, w_m, w_cn}, {4'd5, 4'd3, 4'd1, 1'b0, 1'b1});
        chk("exec1_ready", w_ready, 1'b0);
        wait_wb("exec1");
        issue(10'b10_00_0_1_0011);
        wait_wb("exec2");
        issue(10'b10_00_0_0_0011);
        wait_wb("exec3");
        chk("wrap_acc", w_a, 4'd0);

        // LDA leaves flags alone
        issue(10'b00_0000_0111);
        @(negedge clk);
        chk("lda_flags", {w_a, w_ab, w_zf}, {4'd7, 1'b1, 1'b1});

        // OUT with backpressure, LDB 4 held during it
        issue(10'b11_0000_0000);
        ivalid = 1'b1;
        instr  = 10'b01_0000_0100;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("out_hold", {w_ov, w_od, w_ready}, {1'b1, out_q.size() ? out_q[0] : 4'hx, 1'b0});
            chk("out_b_unchanged", w_b, m_b);
        end
        oready = 1'b1;
        if (out_q.size() == 0) chk("out_sb_empty", 0, 1);
        else chk("out_data_hs", {w_ov, w_od}, {1'b1, out_q.pop_front()});
        @(posedge clk);
        #1;
        oready = 1'b0;
        @(negedge clk);
        chk("out_drop", {w_ov, w_ready, w_b}, {1'b0, 1'b1, m_b});
        @(posedge clk);
        #1;
        ivalid = 1'b0;
        m_b = 4'd4;
        @(negedge clk);
        chk("held_ldb", w_b, 4'd4);

        // back-to-back LDA 2, LDB 9 with valid held
        ivalid = 1'b1;
        instr  = 10'b00_0000_0010;
        @(posedge clk);
        #1;
        chk("b2b_ready1", w_ready, 1'b1);
        instr = 10'b01_0000_1001;
        @(posedge clk);
        #1;
        chk("b2b_ready2", w_ready, 1'b1);
        ivalid = 1'b0;
        @(negedge clk);
        chk("b2b_ab", {w_a, w_b}, {4'd2, 4'd9});

        // reset during OUT drops out_valid asynchronously
        m_acc = 4'd2;
        issue(10'b11_0000_0000);
        #3;
        rst = 1'b1;
        #1;
        chk("rst_out", {w_ov, w_busy, w_a, w_cnt}, 17'd0);
        #4;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        chk("rst_out_ready", w_ready, 1'b1);

        // settle=3 instance: M=1 sel=14 with A=6, B=7
        dsel   = 1'b1;
        settle = 3;
        do_reset();
        issue(10'b00_0000_0110);
        issue(10'b01_0000_0111);
        issue(10'b10_00_1_0_1110);
        chk("s3_inputs", {w_a, w_b, w_sel, w_m}, {4'd6, 4'd7, 4'd14, 1'b1});
        wait_wb("s3_exec");

        // reset mid-settle, not clock aligned
        issue(10'b10_00_1_0_1110);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("rst_exec", {w_busy, w_a, w_b, w_sel, w_ab, w_zf, w_cnt}, 23'd0);
        #3;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        chk("rst_exec_ready", {w_ready, w_a, w_cnt}, {1'b1, 4'd0, 8'd0});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: observed no finish, required finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/alu_exec_ctrl.md
Name: alu_exec_ctrl

Overview:
Execute-stage controller that sits directly upstream of the 4-bit ALU and also consumes its result. It accepts instructions over a valid/ready handshake and holds the A and B operand registers. It drives the ALU's sel/A/B/M/Cn inputs stably for a settle window, then writes F back into the accumulator and records the ALU's all-ones flag. Accumulator values are presented downstream through an output handshake.

Parameters:
SETTLE_CYCLES, 1, cycles the ALU inputs are held before F is captured (legal range 1..15)
CNT_W, 8, width of the executed-operation counter

Ports:
clk  in  1  single system clock, rising edge
rst  in  1  reset, asynchronous, active-high
instr_valid  in  1  instruction present
instr_ready  out  1  controller can accept an instruction
instr  in  10  [9:8] class, [5] M, [4] Cn, [3:0] sel or immediate
alu_sel  out  4  to ALU sel
alu_a  out  4  to ALU A (accumulator)
alu_b  out  4  to ALU B (B register)
alu_m  out  1  to ALU M
alu_cn  out  1  to ALU Cn
alu_f  in  4  ALU result F
alu_abflag  in  1  ALU ABFlag
out_valid  out  1  accumulator value offered downstream
out_ready  in  1  downstream accepts
out_data  out  4  accumulator value
ab_flag  out  1  ABFlag captured at last EXEC writeback
zero_flag  out  1  set when the last EXEC wrote 0 to the accumulator
busy  out  1  state not IDLE
op_count  out  CNT_W  number of EXEC writebacks completed

Behaviour:
- Reset (async, high): state IDLE; accumulator, B, alu_sel, alu_m, alu_cn, out_data = 0; ab_flag, zero_flag, out_valid, busy = 0; op_count = 0; settle counter = 0. Asserting rst mid-EXEC or mid-OUT aborts the operation: no writeback, no count increment, out_valid drops asynchronously.
- instr_ready = 1 only in IDLE. An instruction is accepted on a rising edge when instr_valid && instr_ready. instr_valid while busy is ignored and must be held by the source.
- Class 00 LDA: accumulator <= instr[3:0] at the accept edge; state stays IDLE. Flags are unchanged.
- Class 01 LDB: B <= instr[3:0] at the accept edge; state stays IDLE.
- Class 10 EXEC: at the accept edge, alu_sel <= instr[3:0], alu_m <= instr[5], alu_cn <= instr[4]; settle counter <= SETTLE_CYCLES-1; state goes to EXEC.
  - alu_a and alu_b continuously mirror the accumulator and B.
  - In EXEC, the counter decrements each cycle.
  - At the edge where counter == 0: accumulator <= alu_f, ab_flag <= alu_abflag, zero_flag <= (alu_f == 0), op_count += 1 (wraps modulo 2^CNT_W), state goes to IDLE.
  - Accept to writeback = SETTLE_CYCLES+1 edges inclusive; the ALU inputs do not change during this window.
- Class 11 OUT: at the accept edge, out_data <= accumulator, out_valid <= 1, state goes to OUT.
  - out_data is held stable while out_valid && !out_ready.
  - On the edge with out_ready, out_valid <= 0 and state goes to IDLE.
  - out_ready while out_valid = 0 has no effect.
- alu_sel/alu_m/alu_cn keep their last values outside EXEC; there is no glitching on the ALU inputs.
- The accumulator is 4-bit; F wrap-around (e.g. 15+1 = 0) is taken as-is from the ALU. The controller does no arithmetic on data.
- States: IDLE, EXEC, OUT only. One-hot or binary encoding; an illegal state recovers to IDLE.

Test Plan:
- Reset during EXEC (rst pulsed mid-settle, not aligned to clk) -> all outputs 0 immediately, instr_ready = 1 after release, accumulator 0, op_count 0.
- LDA 5, LDB 3, EXEC {M=0,Cn=1,sel=1} with the ALU attached, SETTLE_CYCLES=1 -> alu_a=5, alu_b=3 during EXEC; accumulator=8 two edges after accept; ab_flag=0, zero_flag=0, op_count=1.
- Accumulator=8, then EXEC {M=0,Cn=1,sel=3} -> accumulator=15, ab_flag=1. Then EXEC {M=0,Cn=0,sel=3} -> accumulator=0 (wrap), zero_flag=1, ab_flag=1, op_count=3.
- OUT with out_ready held low for 4 cycles, then high -> out_valid=1 and out_data=accumulator stable for 5 cycles, drops after the ready edge. instr_ready=0 throughout, and an instruction offered during this time is accepted only afterwards.
- SETTLE_CYCLES=3, EXEC {M=1,Cn=x,sel=14}, A=6, B=7 -> ALU inputs stable for 3 cycles; accumulator=13 on the 4th edge after accept; busy high for exactly 3 cycles.
- Back-to-back LDA 2, LDB 9 on consecutive cycles with instr_valid held -> both accepted in 2 cycles; instr_ready never deasserts.
